// File: rtl/aes_input_buffer.sv
// aes_input_buffer: gathers a key block and a text block from a narrow word
// bus into staging registers, then transfers both to the AES core with a
// one-cycle load pulse once the core is idle.
// Optional feature macro: AES_IB_KEY_REUSE_EN (adds key_reuse_i so a block can
// keep the previously staged key and collect text words only).
module aes_input_buffer #(
  parameter int DATA_W = 32,
  parameter int BLK_W  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  input  logic              core_busy_i,
`ifdef AES_IB_KEY_REUSE_EN
  input  logic              key_reuse_i,
`endif
  output logic [BLK_W-1:0]  key_o,
  output logic [BLK_W-1:0]  text_o,
  output logic              ld_o
);

  localparam int NW = BLK_W / DATA_W;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {KEY, TEXT, LOAD} state_t;

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   cnt;
  logic [BLK_W-1:0] stage_key;
  logic [BLK_W-1:0] stage_text;
  logic            ready_int;
  logic            accept;
  logic            last_word;
  logic            transfer;
  logic            reuse_key;

`ifdef AES_IB_KEY_REUSE_EN
  assign reuse_key = key_reuse_i;
`else
  assign reuse_key = 1'b0;
`endif

  // ready is forced low while reset is held so upstream never sees a false accept
  assign ready_o   = ready_int && !rst;
  assign accept    = valid_i && ready_o;
  assign last_word = (cnt == CW'(NW - 1));
  assign transfer  = (state == LOAD) && !core_busy_i;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= KEY;
    else     state <= next_state;
  end

  // Next-state and ready decode; LOAD holds until the core goes idle
  always_comb begin
    next_state = state;
    ready_int  = 1'b0;
    case (state)
      KEY: begin
        ready_int = 1'b1;
        if (accept && last_word) next_state = TEXT;
      end
      TEXT: begin
        ready_int = 1'b1;
        if (accept && last_word) next_state = LOAD;
      end
      LOAD: begin
        if (!core_busy_i) next_state = reuse_key ? TEXT : KEY;
      end
      default: next_state = KEY;
    endcase
  end

  // Word counter within the current phase; wraps to zero on the last word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      if (last_word) cnt <= '0;
      else           cnt <= cnt + 1'b1;
    end
  end

  // Staging registers; word i of a phase lands in slice i, first word at the LSBs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_key  <= '0;
      stage_text <= '0;
    end else if (accept) begin
      for (int i = 0; i < NW; i++) begin
        if (cnt == CW'(i)) begin
          if (state == KEY) stage_key[DATA_W*i +: DATA_W]  <= data_i;
          else              stage_text[DATA_W*i +: DATA_W] <= data_i;
        end
      end
    end
  end

  // Core-facing registers change only on a transfer so the core can sample them freely
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_o  <= '0;
      text_o <= '0;
      ld_o   <= 1'b0;
    end else begin
      ld_o <= transfer;
      if (transfer) begin
        key_o  <= stage_key;
        text_o <= stage_text;
      end
    end
  end

endmodule

// File: tb/tb_aes_input_buffer.sv
// tb_aes_input_buffer: directed self-checking bench for aes_input_buffer.
// Honours AES_IB_KEY_REUSE_EN when the design is built with it.
module tb_aes_input_buffer;

  localparam int DATA_W = 32;
  localparam int BLK_W  = 128;

  localparam logic [BLK_W-1:0] KEY_A  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [BLK_W-1:0] TEXT_A = 128'h00112233445566778899aabbccddeeff;
  localparam logic [BLK_W-1:0] KEY_B  = 128'hffffffffffffffffffffffffffffffff;
  localparam logic [BLK_W-1:0] TEXT_B = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [BLK_W-1:0] TEXT_C = 128'hffeeddccbbaa99887766554433221100;

  logic              clk;
  logic              rst;
  logic              valid_i;
  logic [DATA_W-1:0] data_i;
  logic              ready_o;
  logic              core_busy_i;
  logic              key_reuse_i;
  logic [BLK_W-1:0]  key_o;
  logic [BLK_W-1:0]  text_o;
  logic              ld_o;

  int compared;
  int mismatched;
  int cyc;
  logic prev_ld;
  int ld_cycles[$];
  logic [BLK_W-1:0] ld_keys[$];

  aes_input_buffer #(.DATA_W(DATA_W), .BLK_W(BLK_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .ready_o     (ready_o),
    .core_busy_i (core_busy_i),
`ifdef AES_IB_KEY_REUSE_EN
    .key_reuse_i (key_reuse_i),
`endif
    .key_o       (key_o),
    .text_o      (text_o),
    .ld_o        (ld_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used to time ld_o pulses
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [BLK_W-1:0] got,
                             input logic [BLK_W-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Records every load pulse and flags any pulse lasting two cycles
  always @(negedge clk) begin
    if (rst) begin
      prev_ld = 1'b0;
    end else begin
      if (ld_o) begin
        checkOutput("ld_twice", {127'd0, prev_ld}, 128'd0);
        ld_cycles.push_back(cyc);
        ld_keys.push_back(key_o);
      end
      prev_ld = ld_o;
    end
  end

  task automatic sendWord(input logic [DATA_W-1:0] w, input bit gap);
    bit acc;
    int guard;
    valid_i = 1'b1;
    data_i  = w;
    guard   = 0;
    forever begin
      acc = ready_o;
      @(posedge clk);
      #1;
      if (acc) break;
      guard++;
      if (guard >= 100) begin
        checkOutput("accept_timeout", 128'd0, 128'd1);
        break;
      end
    end
    if (gap) begin
      valid_i = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [BLK_W-1:0] key, input logic [BLK_W-1:0] text,
                               input bit with_key, input bit gap);
    if (with_key)
      for (int i = 0; i < BLK_W/DATA_W; i++) sendWord(key[DATA_W*i +: DATA_W], gap);
    for (int i = 0; i < BLK_W/DATA_W; i++)
      sendWord(text[DATA_W*i +: DATA_W], (gap && i != BLK_W/DATA_W-1));
    valid_i = 1'b0;
  endtask

  // Called right after the last text accept with the core idle
  task automatic loadCheck(input string tag, input logic [BLK_W-1:0] exp_key,
                           input logic [BLK_W-1:0] exp_text);
    checkOutput({tag, "_ld_early"}, {127'd0, ld_o}, 128'd0);
    checkOutput({tag, "_ready_load"}, {127'd0, ready_o}, 128'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_ld"}, {127'd0, ld_o}, 128'd1);
    checkOutput({tag, "_key"}, key_o, exp_key);
    checkOutput({tag, "_text"}, text_o, exp_text);
    @(posedge clk); #1;
    checkOutput({tag, "_ld_fall"}, {127'd0, ld_o}, 128'd0);
    checkOutput({tag, "_key_hold"}, key_o, exp_key);
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    cyc         = 0;
    prev_ld     = 1'b0;
    rst         = 1'b1;
    valid_i     = 1'b0;
    data_i      = '0;
    core_busy_i = 1'b0;
    key_reuse_i = 1'b0;

    // Reset state
    #2;
    checkOutput("rst_key", key_o, 128'd0);
    checkOutput("rst_text", text_o, 128'd0);
    checkOutput("rst_ld", {127'd0, ld_o}, 128'd0);
    checkOutput("rst_ready", {127'd0, ready_o}, 128'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_rst_ready", {127'd0, ready_o}, 128'd1);

    // Basic load
    $display("[TB] basic load");
    applyStimulus(KEY_A, TEXT_A, 1'b1, 1'b0);
    loadCheck("basic", KEY_A, TEXT_A);

    // Busy stall: core busy from the cycle LOAD is entered
    $display("[TB] busy stall");
    applyStimulus(KEY_B, TEXT_B, 1'b1, 1'b0);
    core_busy_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("stall_ready", {127'd0, ready_o}, 128'd0);
      checkOutput("stall_ld", {127'd0, ld_o}, 128'd0);
      checkOutput("stall_key", key_o, KEY_A);
      checkOutput("stall_text", text_o, TEXT_A);
    end
    core_busy_i = 1'b0;
    @(posedge clk); #1;
    checkOutput("stall_release_ld", {127'd0, ld_o}, 128'd1);
    checkOutput("stall_release_key", key_o, KEY_B);
    checkOutput("stall_release_text", text_o, TEXT_B);
    @(posedge clk); #1;

    // Gapped valid
    $display("[TB] gapped valid");
    applyStimulus(KEY_A, TEXT_A, 1'b1, 1'b1);
    loadCheck("gapped", KEY_A, TEXT_A);

    // Reset mid-text
    $display("[TB] reset mid-text");
    for (int i = 0; i < BLK_W/DATA_W; i++) sendWord(KEY_B[DATA_W*i +: DATA_W], 1'b0);
    sendWord(TEXT_B[31:0], 1'b0);
    sendWord(TEXT_B[63:32], 1'b0);
    valid_i = 1'b0;
    ld_cycles.delete();
    ld_keys.delete();
    rst = 1'b1;
    #1;
    checkOutput("midrst_key", key_o, 128'd0);
    checkOutput("midrst_text", text_o, 128'd0);
    checkOutput("midrst_ld", {127'd0, ld_o}, 128'd0);
    checkOutput("midrst_ready", {127'd0, ready_o}, 128'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("midrst_no_ld", 128'(ld_cycles.size()), 128'd0);
    applyStimulus(KEY_A, TEXT_A, 1'b1, 1'b0);
    loadCheck("after_rst", KEY_A, TEXT_A);

    // Back-to-back blocks
    $display("[TB] back-to-back");
    ld_cycles.delete();
    ld_keys.delete();
    applyStimulus(KEY_A, TEXT_A, 1'b1, 1'b0);
    valid_i = 1'b1;
    applyStimulus(KEY_B, TEXT_B, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("b2b_count", 128'(ld_cycles.size()), 128'd2);
    if (ld_cycles.size() == 2) begin
      checkOutput("b2b_spacing", 128'(ld_cycles[1] - ld_cycles[0]), 128'd9);
      checkOutput("b2b_key0", ld_keys[0], KEY_A);
      checkOutput("b2b_key1", ld_keys[1], KEY_B);
    end
    checkOutput("b2b_text", text_o, TEXT_B);

`ifdef AES_IB_KEY_REUSE_EN
    // Key reuse: second block sends text only
    $display("[TB] key reuse");
    key_reuse_i = 1'b1;
    applyStimulus(KEY_A, TEXT_A, 1'b1, 1'b0);
    loadCheck("reuse1", KEY_A, TEXT_A);
    key_reuse_i = 1'b0;
    checkOutput("reuse_ready", {127'd0, ready_o}, 128'd1);
    applyStimulus(KEY_B, TEXT_C, 1'b0, 1'b0);
    loadCheck("reuse2", KEY_A, TEXT_C);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Absolute watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
